// File: rtl/alu_result_collector.sv
// Collects tinyalu results into a wide LSB-first package with a valid/ready handoff,
// and raises sticky flags on start/done protocol errors.
module alu_result_collector #(
  parameter int unsigned NUM           = 100,
  parameter int unsigned RES_W         = 16,
  parameter int unsigned PACKAGE_WIDTH = 1600,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [2:0]               op_i,
  input  logic                     done_i,
  input  logic [RES_W-1:0]         result_i,
  output logic                     pkg_valid_o,
  input  logic                     pkg_ready_i,
  output logic [PACKAGE_WIDTH-1:0] pkg_data_o,
  output logic [31:0]              pkg_count_o,
  output logic [7:0]               fill_o,
  output logic                     overflow_o,
  output logic                     timeout_o,
  output logic                     spurious_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
  localparam logic [7:0]    FillLast  = 8'(NUM - 1);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e                   r_state;
  logic [PACKAGE_WIDTH-1:0] r_pkg_data;
  logic [7:0]               r_fill;
  logic [31:0]              r_pkg_count;
  logic                     r_overflow;
  logic                     r_timeout;
  logic                     r_spurious;
  logic                     r_pending;
  logic [TW-1:0]            r_timer;

  logic [PACKAGE_WIDTH-1:0] w_shifted;
  logic [PACKAGE_WIDTH-1:0] w_first;

  // New results enter at the top so that the first one ends up at the LSB.
  assign w_shifted = {result_i, r_pkg_data[PACKAGE_WIDTH-1:RES_W]};
  assign w_first   = {result_i, {(PACKAGE_WIDTH - RES_W){1'b0}}};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= StCollect;
      r_pkg_data  <= '0;
      r_fill      <= '0;
      r_pkg_count <= '0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
      r_spurious  <= 1'b0;
      r_pending   <= 1'b0;
      r_timer     <= '0;
    end else begin
      unique case (r_state)
        StCollect: begin
          if (done_i) begin
            r_pkg_data <= w_shifted;
            r_fill     <= 8'(r_fill + 8'd1);
            if (r_fill == FillLast) r_state <= StHold;
          end
        end
        StHold: begin
          if (pkg_ready_i) begin
            r_pkg_count <= r_pkg_count + 32'd1;
            r_state     <= StCollect;
            // A done coincident with the transfer seeds the next package.
            if (done_i) begin
              r_pkg_data <= w_first;
              r_fill     <= 8'd1;
            end else begin
              r_pkg_data <= '0;
              r_fill     <= 8'd0;
            end
          end else if (done_i) begin
            r_overflow <= 1'b1;
          end
        end
        default: r_state <= StCollect;
      endcase

      if (r_pending) begin
        if (done_i) begin
          r_pending <= 1'b0;
        end else if (r_timer == TimerLast) begin
          r_timeout <= 1'b1;
          r_pending <= 1'b0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end else if (done_i) begin
        r_spurious <= 1'b1;
      end else if (start_i && (op_i != 3'd0)) begin
        r_pending <= 1'b1;
        r_timer   <= '0;
      end
    end
  end

  assign pkg_valid_o = (r_state == StHold);
  assign pkg_data_o  = r_pkg_data;
  assign pkg_count_o = r_pkg_count;
  assign fill_o      = r_fill;
  assign overflow_o  = r_overflow;
  assign timeout_o   = r_timeout;
  assign spurious_o  = r_spurious;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: a queue of expected results is filled as
// dones are driven and compared entry by entry against each completed package.
module tb_alu_result_collector;

  localparam int unsigned NUM = 100;
  localparam int unsigned RW  = 16;
  localparam int unsigned PW  = 1600;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    op;
  logic          done;
  logic [RW-1:0] result;
  logic          pkg_valid;
  logic          pkg_ready;
  logic [PW-1:0] pkg_data;
  logic [31:0]   pkg_count;
  logic [7:0]    fill;
  logic          overflow;
  logic          timeout;
  logic          spurious;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [RW-1:0] exp_q[$];

  alu_result_collector #(
    .NUM(NUM), .RES_W(RW), .PACKAGE_WIDTH(PW), .TIMEOUT(16)
  ) u_dut (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .op_i(op), .done_i(done),
    .result_i(result), .pkg_valid_o(pkg_valid), .pkg_ready_i(pkg_ready),
    .pkg_data_o(pkg_data), .pkg_count_o(pkg_count), .fill_o(fill),
    .overflow_o(overflow), .timeout_o(timeout), .spurious_o(spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(pkg_valid), 32'd0);
    check({tag, " fill"}, 32'(fill), 32'd0);
    check({tag, " count"}, pkg_count, 32'd0);
    check({tag, " data"}, 32'(|pkg_data), 32'd0);
    check({tag, " flags"}, {29'd0, overflow, timeout, spurious}, 32'd0);
  endtask

  task automatic do_reset();
    start = 1'b0; op = 3'd0; done = 1'b0; result = '0; pkg_ready = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // start for one cycle, done `gap` cycles after the start edge
  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input int gap, input bit capture);
    logic [15:0] r;
    r = (o == 3'd4) ? 16'(a * b) : 16'(a + b);
    start = 1'b1; op = o;
    tick();
    start = 1'b0; op = 3'd0;
    for (int i = 1; i < gap; i++) tick();
    done = 1'b1; result = r;
    if (capture) exp_q.push_back(r);
    tick();
    done = 1'b0; result = '0;
  endtask

  task automatic check_pkg(input string tag);
    check({tag, " qsize"}, 32'(exp_q.size() >= NUM), 32'd1);
    for (int i = 0; i < int'(NUM); i++) begin
      if (i < exp_q.size())
        check($sformatf("%s entry%0d", tag, i), 32'(pkg_data[RW*i +: RW]), 32'(exp_q[i]));
    end
  endtask

  task automatic drop_pkg();
    for (int i = 0; i < int'(NUM); i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    // Full package with consumer always ready
    do_reset();
    check_idle("reset");
    pkg_ready = 1'b1;
    for (int k = 0; k < 99; k++) issue(3'd1, 16'(k), 16'd1, 1, 1'b1);
    check("t1 fill99", 32'(fill), 32'd99);
    check("t1 novalid", 32'(pkg_valid), 32'd0);
    issue(3'd1, 16'd99, 16'd1, 1, 1'b1);
    check("t1 valid", 32'(pkg_valid), 32'd1);
    check("t1 fill100", 32'(fill), 32'd100);
    check("t1 lsb", 32'(pkg_data[15:0]), 32'd1);
    check("t1 msb", 32'(pkg_data[1599:1584]), 32'd100);
    check_pkg("t1");
    tick();
    drop_pkg();
    check("t1 valid drop", 32'(pkg_valid), 32'd0);
    check("t1 count", pkg_count, 32'd1);
    check("t1 fill0", 32'(fill), 32'd0);
    check("t1 flags", {29'd0, overflow, timeout, spurious}, 32'd0);

    // Held package with two dropped results
    do_reset();
    for (int k = 0; k < 100; k++) issue(3'd1, 16'(3 * k), 16'd7, 1, 1'b1);
    check("t2 valid1", 32'(pkg_valid), 32'd1);
    issue(3'd1, 16'h1111, 16'd1, 1, 1'b0);
    check("t2 valid3", 32'(pkg_valid), 32'd1);
    issue(3'd1, 16'h2222, 16'd1, 1, 1'b0);
    check("t2 valid5", 32'(pkg_valid), 32'd1);
    check("t2 overflow", 32'(overflow), 32'd1);
    check("t2 fill", 32'(fill), 32'd100);
    check_pkg("t2 held");
    pkg_ready = 1'b1;
    tick();
    pkg_ready = 1'b0;
    drop_pkg();
    check("t2 valid drop", 32'(pkg_valid), 32'd0);
    check("t2 fill0", 32'(fill), 32'd0);
    check("t2 count", pkg_count, 32'd1);

    // Done coincident with transfer
    do_reset();
    for (int k = 0; k < 100; k++) issue(3'd1, 16'(k), 16'd5, 1, 1'b1);
    check_pkg("t3 first");
    drop_pkg();
    start = 1'b1; op = 3'd1;
    tick();
    start = 1'b0; op = 3'd0;
    done = 1'b1; result = 16'hBEEF; pkg_ready = 1'b1;
    exp_q.push_back(16'hBEEF);
    tick();
    done = 1'b0; result = '0;
    check("t3 count", pkg_count, 32'd1);
    check("t3 fill", 32'(fill), 32'd1);
    check("t3 overflow", 32'(overflow), 32'd0);
    check("t3 valid", 32'(pkg_valid), 32'd0);
    check("t3 top", 32'(pkg_data[1599:1584]), 32'hBEEF);
    for (int k = 0; k < 99; k++) issue(3'd1, 16'(k), 16'd2, 1, 1'b1);
    check("t3 valid2", 32'(pkg_valid), 32'd1);
    check("t3 entry0", 32'(pkg_data[15:0]), 32'hBEEF);
    check_pkg("t3 second");
    tick();
    drop_pkg();
    check("t3 count2", pkg_count, 32'd2);
    pkg_ready = 1'b0;

    // Timeout on withheld done, then a clean late command
    do_reset();
    start = 1'b1; op = 3'd4;
    tick();
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < 10; i++) tick();
    check("t4 early", 32'(timeout), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("t4 timeout", 32'(timeout), 32'd1);
    issue(3'd4, 16'd6, 16'd7, 3, 1'b1);
    check("t4 spurious", 32'(spurious), 32'd0);
    check("t4 overflow", 32'(overflow), 32'd0);
    check("t4 fill", 32'(fill), 32'd1);
    check("t4 data", 32'(pkg_data[1599:1584]), 32'd42);

    // Spurious done, then a no-op start that must not arm the timer
    do_reset();
    done = 1'b1; result = 16'h0055;
    tick();
    done = 1'b0; result = '0;
    check("t5 spurious", 32'(spurious), 32'd1);
    check("t5 fill", 32'(fill), 32'd1);
    check("t5 data", 32'(pkg_data[1599:1584]), 32'h0055);
    exp_q.push_back(16'h0055);
    start = 1'b1; op = 3'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t5 notimeout", 32'(timeout), 32'd0);

    // Reset mid-package, then a fresh package
    for (int k = 0; k < 36; k++) issue(3'd1, 16'(k), 16'd9, 1, 1'b1);
    check("t6 fill37", 32'(fill), 32'd37);
    reset_n = 1'b0;
    #1;
    check_idle("t6 async");
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    pkg_ready = 1'b1;
    for (int k = 0; k < 100; k++) issue(3'd1, 16'(k + 500), 16'd3, 1, 1'b1);
    check("t6 valid", 32'(pkg_valid), 32'd1);
    check("t6 entry0", 32'(pkg_data[15:0]), 32'd503);
    check_pkg("t6");
    tick();
    check("t6 count", pkg_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before limit");
    $fatal(1, "watchdog");
  end

endmodule
